// File: rtl/pipe_seg_adder.sv
// Segmented, carry-pipelined adder/subtractor/xor/pass with a valid/ready handshake.
// Each stage resolves one SEG-bit slice; operand and result bits skew along one packed bus.

module pipe_seg_cell #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] sa,
  input  logic [SEG-1:0] sb,
  input  logic           ci,
  input  logic [1:0]     md,
  output logic [SEG-1:0] res,
  output logic           co
);
  logic [SEG:0] add;

  assign add = {1'b0, sa} + {1'b0, sb} + {{SEG{1'b0}}, ci};
  assign co  = add[SEG];

  always_comb begin
    case (md)
      2'b10:   res = sa ^ sb;
      2'b11:   res = sa;
      default: res = add[SEG-1:0];
    endcase
  end
endmodule

module pipe_seg_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SEG;
  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_SUB = 2'b01;

  // Stage k output is {b slices k+1.. (reversed), a slices above k, result slices 0..k};
  // it shrinks by SEG per stage and the last one is exactly the WIDTH-bit result.
  function automatic int off(input int k);
    return k * 2 * WIDTH - SEG * k * (k + 1) / 2;
  endfunction

  localparam int BUSW = off(STAGES);

  logic                        adv;
  logic                        accept;
  logic [STAGES:0]             vld_pipe;
  logic [STAGES-1:0]           vld_q;
  logic [BUSW-1:0]             pbus;
  logic [STAGES-1:0]           cy;
  logic [STAGES-1:0][1:0]      md_q;
  logic                        ovf_q;
  logic [WIDTH-1:0]            beff;
  logic [WIDTH-1:0]            brev;
  logic                        cin_eff;
  logic                        arith_last;

  assign out_valid = vld_pipe[STAGES] & ~rst;
  assign in_ready  = !(out_valid && !out_ready);
  assign adv       = in_ready;
  assign accept    = in_valid & in_ready & ~rst;
  assign vld_pipe  = {vld_q, accept};

  always_ff @(posedge clk) begin
    if (rst)      vld_q <= '0;
    else if (adv) vld_q <= vld_pipe[STAGES-1:0];
  end

  assign beff    = (mode == M_SUB) ? ~b : b;
  assign cin_eff = (mode == M_SUB) ? 1'b1 : ((mode == M_ADD) ? cin : 1'b0);

  // B slices are stored high-to-low so the slice a stage consumes is always on top.
  always_comb begin
    brev = '0;
    for (int j = 0; j < STAGES; j++)
      brev[(STAGES-1-j)*SEG +: SEG] = beff[j*SEG +: SEG];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int IW    = 2 * WIDTH - k * SEG;
    localparam int OW    = IW - SEG;
    localparam int OFF_O = off(k);

    logic [IW-1:0]  din;
    logic           ci;
    logic [1:0]     md;
    logic [SEG-1:0] res;
    logic           co;
    logic [OW-1:0]  nxt;

    if (k == 0) begin : g_head
      assign din = {brev, a};
      assign ci  = cin_eff;
      assign md  = mode;
    end else begin : g_body
      localparam int OFF_I = off(k - 1);
      assign din = pbus[OFF_I +: IW];
      assign ci  = cy[k-1];
      assign md  = md_q[k-1];
    end

    pipe_seg_cell #(.SEG(SEG)) u_cell (
      .sa  (din[k*SEG +: SEG]),
      .sb  (din[IW-1 -: SEG]),
      .ci  (ci),
      .md  (md),
      .res (res),
      .co  (co)
    );

    always_comb begin
      nxt              = din[OW-1:0];
      nxt[k*SEG +: SEG] = res;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pbus[OFF_O +: OW] <= '0;
        cy[k]             <= 1'b0;
        md_q[k]           <= 2'b00;
      end else if (adv) begin
        pbus[OFF_O +: OW] <= nxt;
        cy[k]             <= co;
        md_q[k]           <= md;
      end
    end

    if (k == STAGES - 1) begin : g_ovf
      // MSBs of both effective operands are still on the bus at the last slice.
      logic ovf_n;
      assign ovf_n = (din[WIDTH-1] == din[IW-1]) && (res[SEG-1] != din[WIDTH-1]);

      always_ff @(posedge clk) begin
        if (rst)      ovf_q <= 1'b0;
        else if (adv) ovf_q <= ovf_n;
      end
    end
  end

  assign arith_last = (md_q[STAGES-1] == M_ADD) || (md_q[STAGES-1] == M_SUB);

  assign sum  = rst ? '0 : pbus[BUSW-1 -: WIDTH];
  assign cout = ~rst & arith_last & cy[STAGES-1];
  assign ovf  = ~rst & arith_last & ovf_q;
endmodule
